// File: rtl/video_timing_if.sv
// Display-side bundle for the raster timing generator.
// The generator drives the panel/pixel outputs; the host drives vblank_ack.
interface video_timing_if;
  logic        disp_hsync;
  logic        disp_vsync;
  logic        disp_de;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;
  logic        int_vblank;
  logic        vblank_ack;

  modport master (
    output disp_hsync,
    output disp_vsync,
    output disp_de,
    output pix_x,
    output pix_y,
    output frame_start,
    output int_vblank,
    input  vblank_ack
  );

  modport slave (
    input  disp_hsync,
    input  disp_vsync,
    input  disp_de,
    input  pix_x,
    input  pix_y,
    input  frame_start,
    input  int_vblank,
    output vblank_ack
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator, CEA 720p60 by default; all outputs registered.
// VIDEO_TIMING_IRQ_LATCH_EN makes int_vblank sticky until vblank_ack.
module video_timing #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic          pixel_clk,
  input  logic          reset,
  video_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_bad_h
    $error("video_timing: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_bad_v
    $error("video_timing: V_TOTAL exceeds 1024");
  end

  // One extra bit so sync end bounds of 2048/1024 still compare correctly
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [11:0] hc;
  logic [10:0] vc;
  logic        h_last;
  logic        v_last;
  logic        act;
  logic        hs_on;
  logic        vs_on;
  logic        vblank_evt;
  logic        fs_evt;

  always_comb begin
    hc         = {1'b0, hcnt};
    vc         = {1'b0, vcnt};
    h_last     = (hc == H_LAST);
    v_last     = (vc == V_LAST);
    act        = (hc < H_ACT) && (vc < V_ACT);
    hs_on      = (hc >= HS_BEG) && (hc < HS_END);
    vs_on      = (vc >= VS_BEG) && (vc < VS_END);
    vblank_evt = (hcnt == '0) && (vc == V_ACT);
    fs_evt     = (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_last ? '0 : hcnt + 11'd1;
      if (h_last) begin
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vid.disp_de     <= 1'b0;
      vid.disp_hsync  <= ~HSYNC_POL;
      vid.disp_vsync  <= ~VSYNC_POL;
      vid.pix_x       <= '0;
      vid.pix_y       <= '0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.disp_de     <= act;
      vid.disp_hsync  <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vid.disp_vsync  <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      vid.pix_x       <= act ? hcnt : '0;
      vid.pix_y       <= act ? vcnt : '0;
      vid.frame_start <= fs_evt;
    end
  end

`ifdef VIDEO_TIMING_IRQ_LATCH_EN
  // Set has priority so an ack racing a new vblank never loses it
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vid.int_vblank <= 1'b0;
    end else if (vblank_evt) begin
      vid.int_vblank <= 1'b1;
    end else if (vid.vblank_ack) begin
      vid.int_vblank <= 1'b0;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = vid.vblank_ack;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vid.int_vblank <= 1'b0;
    end else begin
      vid.int_vblank <= vblank_evt;
    end
  end
`endif

endmodule
